screen_writer: RTL and testbench

SCREEN_WRITER -- requirements
Module: screen_writer

---
 rtl/screen_writer.sv | 156 +++++++++++++++
 tb/tb_screen_writer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_writer.sv
// ============================================================================
//  Module      : screen_writer
//  Description : Buffers CPU pixel-word writes in a 4-deep FIFO and streams
//                them into a single-port VRAM. The display reader has
//                priority on that port. A clear request fills all 8192 words
//                with a latched fill word once the queued writes are done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module screen_writer (
  input  logic        clk,
  input  logic        resetn,
  // CPU write channel
  input  logic        cpu_wvalid,
  input  logic [12:0] cpu_waddr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_wready,
  // Clear request
  input  logic        clear_start,
  input  logic [15:0] clear_data,
  // VRAM port (shared with the display reader)
  input  logic        vram_rden,
  output logic        vram_wren,
  output logic [12:0] vram_waddr,
  output logic [15:0] vram_wdata,
  // Status
  output logic        busy
);

  localparam int          DEPTH     = 4;
  localparam int          PTR_W     = 2;
  localparam int          CNT_W     = 3;
  localparam logic [12:0] C_LAST_WA = 13'h1FFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t              r_state;
  logic [12:0]         r_clr_cnt;
  logic [15:0]         r_fill;

  logic [12:0]         r_fifo_addr [DEPTH];
  logic [15:0]         r_fifo_data [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_in_clear;
  logic [CNT_W-1:0]    w_count_next;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_in_clear = (r_state == ST_CLEAR);

  // CPU is accepted only while idle with room in the queue and out of reset
  assign cpu_wready = resetn && (r_state == ST_IDLE) && !w_full;
  assign w_push     = cpu_wvalid && cpu_wready;

  // Reader always wins the VRAM port; reset blocks any write in its cycle
  assign vram_wren  = resetn && !vram_rden && (w_in_clear || !w_empty);

  // The FIFO head is consumed only by normal (non-clear) VRAM writes
  assign w_pop      = vram_wren && !w_in_clear;

  assign vram_waddr = w_in_clear ? r_clr_cnt : r_fifo_addr[r_rptr];
  assign vram_wdata = w_in_clear ? r_fill    : r_fifo_data[r_rptr];

  assign busy       = resetn && ((r_state != ST_IDLE) || !w_empty);

  // Occupancy after this edge; push and pop together leave it unchanged
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  // FIFO storage: entries need no reset, validity is tracked by the count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= cpu_waddr;
      r_fifo_data[r_wptr] <= cpu_wdata;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Control FSM: idle -> drain queued writes -> sweep all words with fill
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
      r_fill    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A write accepted alongside clear_start is already queued and
          // will drain ahead of the sweep
          if (clear_start) begin
            r_fill  <= clear_data;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // No pushes happen here, so the queue only shrinks
          if (w_count_next == '0) begin
            r_clr_cnt <= '0;
            r_state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          // Advance only when the word was actually written
          if (vram_wren) begin
            if (r_clr_cnt == C_LAST_WA) begin
              r_clr_cnt <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_clr_cnt <= r_clr_cnt + 13'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_screen_writer.sv
// ============================================================================
//  Module      : tb_screen_writer
//  Description : Directed self-checking bench for screen_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_screen_writer;

  logic        clk;
  logic        resetn;
  logic        cpu_wvalid;
  logic [12:0] cpu_waddr;
  logic [15:0] cpu_wdata;
  logic        cpu_wready;
  logic        clear_start;
  logic [15:0] clear_data;
  logic        vram_rden;
  logic        vram_wren;
  logic [12:0] vram_waddr;
  logic [15:0] vram_wdata;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  screen_writer u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .cpu_wvalid  (cpu_wvalid),
    .cpu_waddr   (cpu_waddr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wready  (cpu_wready),
    .clear_start (clear_start),
    .clear_data  (clear_data),
    .vram_rden   (vram_rden),
    .vram_wren   (vram_wren),
    .vram_waddr  (vram_waddr),
    .vram_wdata  (vram_wdata),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nw;
    int bad;
    int found;

    resetn      = 1'b0;
    cpu_wvalid  = 1'b0;
    cpu_waddr   = '0;
    cpu_wdata   = '0;
    clear_start = 1'b0;
    clear_data  = '0;
    vram_rden   = 1'b0;

    // ---------------- Reset state ----------------
    step(); step();
    #1;
    check_val("rst_wren",   32'(vram_wren),  32'd0);
    check_val("rst_wready", 32'(cpu_wready), 32'd0);
    check_val("rst_busy",   32'(busy),       32'd0);
    step();
    resetn = 1'b1;
    #1;
    check_val("post_rst_wready", 32'(cpu_wready), 32'd1);
    check_val("post_rst_busy",   32'(busy),       32'd0);

    // ---------------- Single write ----------------
    cpu_wvalid = 1'b1; cpu_waddr = 13'h0123; cpu_wdata = 16'hA5A5;
    #1;
    check_val("single_wready",     32'(cpu_wready), 32'd1);
    check_val("single_no_early_wr", 32'(vram_wren), 32'd0);
    step();
    cpu_wvalid = 1'b0;
    #1;
    check_val("single_wren",  32'(vram_wren),  32'd1);
    check_val("single_waddr", 32'(vram_waddr), 32'h0123);
    check_val("single_wdata", 32'(vram_wdata), 32'hA5A5);
    check_val("single_busy",  32'(busy),       32'd1);
    step();
    #1;
    check_val("single_done_wren", 32'(vram_wren), 32'd0);
    check_val("single_done_busy", 32'(busy),      32'd0);

    // ---------------- Full FIFO with reader holding the port ----------------
    vram_rden = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_wvalid = 1'b1;
      cpu_waddr  = 13'(16 + i);
      cpu_wdata  = 16'(16'h1000 + i);
      #1;
      check_val($sformatf("full_wready%0d", i), 32'(cpu_wready), (i < 4) ? 32'd1 : 32'd0);
      check_val($sformatf("full_blocked%0d", i), 32'(vram_wren), 32'd0);
      step();
    end
    cpu_wvalid = 1'b0;
    vram_rden  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val($sformatf("full_wren%0d", i),  32'(vram_wren),  32'd1);
      check_val($sformatf("full_waddr%0d", i), 32'(vram_waddr), 32'(16 + i));
      check_val($sformatf("full_wdata%0d", i), 32'(vram_wdata), 32'(16'h1000 + i));
      step();
    end
    #1;
    check_val("full_drained_wren", 32'(vram_wren), 32'd0);
    check_val("full_drained_busy", 32'(busy),      32'd0);

    // ---------------- Contention: rden 1,0,1,0 ----------------
    cpu_wvalid = 1'b1; cpu_waddr = 13'h0ABC; cpu_wdata = 16'h5555;
    step();
    cpu_wvalid = 1'b0;
    nw = 0;
    for (int k = 0; k < 4; k++) begin
      vram_rden = (k % 2 == 0);
      #1;
      if (vram_rden) begin
        check_val($sformatf("cont_yield%0d", k), 32'(vram_wren), 32'd0);
      end
      if (vram_wren) begin
        nw++;
        check_val("cont_waddr", 32'(vram_waddr), 32'h0ABC);
        check_val("cont_wdata", 32'(vram_wdata), 32'h5555);
        check_val("cont_first_free_cycle", 32'(k), 32'd1);
      end
      step();
    end
    vram_rden = 1'b0;
    check_val("cont_write_count", 32'(nw), 32'd1);

    // ---------------- Clear after queued writes ----------------
    vram_rden = 1'b1;
    cpu_wvalid = 1'b1; cpu_waddr = 13'h0100; cpu_wdata = 16'h0001;
    step();
    cpu_waddr = 13'h0200; cpu_wdata = 16'h0002;
    step();
    // Third write and the clear request share a cycle
    cpu_waddr = 13'h0300; cpu_wdata = 16'h0003;
    clear_start = 1'b1; clear_data = 16'hFFFF;
    #1;
    check_val("clr_same_cycle_wready", 32'(cpu_wready), 32'd1);
    step();
    cpu_wvalid = 1'b0; clear_start = 1'b0; clear_data = 16'h0000;
    vram_rden = 1'b0;
    #1;
    check_val("drain_wready", 32'(cpu_wready), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      check_val($sformatf("drain_wren%0d", i),  32'(vram_wren),  32'd1);
      check_val($sformatf("drain_waddr%0d", i), 32'(vram_waddr), 32'(i * 256));
      check_val($sformatf("drain_wdata%0d", i), 32'(vram_wdata), 32'(i));
      step();
      #1;
    end

    nw  = 0;
    bad = 0;
    for (int cyc = 0; cyc < 9000 && nw < 8192; cyc++) begin
      clear_start = (cyc == 4000);
      clear_data  = (cyc == 4000) ? 16'h1234 : 16'h0000;
      vram_rden   = (cyc == 5000);
      #1;
      if (vram_rden && vram_wren) bad++;
      if (vram_wren) begin
        if (vram_waddr != nw[12:0] || vram_wdata != 16'hFFFF) bad++;
        nw++;
      end
      if (!busy || cpu_wready) bad++;
      step();
    end
    clear_start = 1'b0;
    vram_rden   = 1'b0;
    check_val("clear_write_count", 32'(nw),  32'd8192);
    check_val("clear_seq_errors",  32'(bad), 32'd0);
    #1;
    check_val("clear_done_busy",   32'(busy),       32'd0);
    check_val("clear_done_wren",   32'(vram_wren),  32'd0);
    check_val("clear_done_wready", 32'(cpu_wready), 32'd1);

    // ---------------- Reset mid-clear at counter 100 ----------------
    clear_start = 1'b1; clear_data = 16'h00FF;
    step();
    clear_start = 1'b0;
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      #1;
      if (vram_wren && vram_waddr == 13'd100) found = 1;
      else step();
    end
    check_val("reach_cnt100", 32'(found), 32'd1);
    check_val("cnt100_wdata", 32'(vram_wdata), 32'h00FF);
    resetn = 1'b0;
    #1;
    check_val("midclr_rst_wren",   32'(vram_wren),  32'd0);
    check_val("midclr_rst_busy",   32'(busy),       32'd0);
    check_val("midclr_rst_wready", 32'(cpu_wready), 32'd0);
    step();
    resetn = 1'b1;
    #1;
    check_val("midclr_rel_wready", 32'(cpu_wready), 32'd1);
    check_val("midclr_rel_busy",   32'(busy),       32'd0);
    nw = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (vram_wren) nw++;
      step();
    end
    check_val("midclr_no_writes", 32'(nw), 32'd0);

    // ---------------- Reset discards queued FIFO entries ----------------
    vram_rden  = 1'b1;
    cpu_wvalid = 1'b1; cpu_waddr = 13'h1ABC; cpu_wdata = 16'hBEEF;
    step();
    cpu_wvalid = 1'b0;
    resetn = 1'b0;
    vram_rden = 1'b0;
    #1;
    check_val("fifo_rst_wren", 32'(vram_wren), 32'd0);
    step();
    resetn = 1'b1;
    nw = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (vram_wren) nw++;
      step();
    end
    check_val("fifo_rst_no_writes", 32'(nw), 32'd0);
    #1;
    check_val("fifo_rst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
